// File: rtl/dma_pkg.sv
// Shared types and constants for the multi-channel DMA timing-control block.
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        READ,
        WRITE,
        DONE
    } dma_tc_state_e;

    localparam int MAX_CH = 8;
    localparam int WAIT_W = 4;

    function automatic int wrap_inc(input int value, input int modulus);
        return (value + 1 == modulus) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/dma_prio_arbiter.sv
// Combinational DREQ arbiter: fixed (index 0 first) or rotating search from ptr.
module dma_prio_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_vec,
    input  logic [CH_W-1:0]   ptr,
    input  logic              rot,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_valid
);

    always_comb begin
        logic [CH_W-1:0] idx;
        // NOTE: every output gets a default before the loop, so no latch is inferred.
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = CH_W'(((rot ? int'(ptr) : 0) + k) % NUM_CH);
            if (!grant_valid && req_vec[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/dma_tc_multich.sv
// Timing-control FSM: arbitrates DREQs, holds the bus via HRQ/HLDA and
// sequences READ/WRITE strobes with wait states until terminal count.
module dma_tc_multich
    import dma_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CH_W        = $clog2(NUM_CH),
    parameter int WAIT_CYCLES = 0,
    parameter bit ROT_PRIO    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              prio_rot_wr,
    input  logic              prio_rot_in,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] dreq,
    input  logic              hlda,
    input  logic              tc,
    output logic              hrq,
    output logic              program_mode,
    output logic              state_read,
    output logic              state_write,
    output logic              state_done,
    output logic              ior,
    output logic              iow,
    output logic [NUM_CH-1:0] dack,
    output logic [CH_W-1:0]   ch_sel,
    output logic              eop
);

    dma_tc_state_e     state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
    logic              mode_q, mode_d;
    logic              abort_q, abort_d;
    logic              program_mode_q, program_mode_d;

    logic [NUM_CH-1:0] req_vec;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_valid;
    logic              phase_last;

    assign req_vec    = dreq & ch_en;
    assign phase_last = (wait_q == WAIT_W'(WAIT_CYCLES));

    dma_prio_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req_vec     (req_vec),
        .ptr         (ptr_q),
        .rot         (mode_q),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        ptr_d    = ptr_q;
        ch_sel_d = ch_sel_q;
        mode_d   = mode_q;
        abort_d  = abort_q;
        unique case (state_q)
            IDLE: begin
                wait_d  = '0;
                abort_d = 1'b0;
                if (prio_rot_wr) mode_d = prio_rot_in;
                if (cs_n && |req_vec) state_d = HOLD;
            end
            HOLD: begin
                if (hlda && grant_valid) begin
                    ch_sel_d = grant_idx;
                    state_d  = READ;
                end else if (!grant_valid) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (!hlda) abort_d = 1'b1;
                if (phase_last) begin
                    wait_d  = '0;
                    state_d = WRITE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            WRITE: begin
                if (!hlda) abort_d = 1'b1;
                if (phase_last) begin
                    wait_d = '0;
                    // A lost bus grant ends the block quietly; tc is irrelevant then.
                    if (abort_q || !hlda) state_d = IDLE;
                    else if (tc)          state_d = DONE;
                    else                  state_d = READ;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DONE: begin
                if (mode_q) ptr_d = CH_W'(wrap_inc(int'(ch_sel_q), NUM_CH));
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        program_mode_d = (state_d == IDLE) && !cs_n;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q        <= IDLE;
            wait_q         <= '0;
            ptr_q          <= '0;
            ch_sel_q       <= '0;
            mode_q         <= ROT_PRIO;
            abort_q        <= 1'b0;
            program_mode_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            ptr_q          <= ptr_d;
            ch_sel_q       <= ch_sel_d;
            mode_q         <= mode_d;
            abort_q        <= abort_d;
            program_mode_q <= program_mode_d;
        end
    end

    assign hrq          = (state_q == HOLD) || (state_q == READ) || (state_q == WRITE);
    assign program_mode = program_mode_q;
    assign state_read   = (state_q == READ);
    assign state_write  = (state_q == WRITE);
    assign state_done   = (state_q == DONE);
    assign ior          = state_read;
    assign iow          = state_write;
    assign eop          = state_done;
    assign ch_sel       = ch_sel_q;
    assign dack         = (state_read || state_write) ? (NUM_CH'(1) << ch_sel_q) : '0;

endmodule

// File: tb/tb_dma_tc_multich.sv
// Randomized scoreboard bench for dma_tc_multich: expected block records are
// queued at grant time and checked by a monitor when each block ends.
module tb_dma_tc_multich;

    localparam int NUM_CH      = 4;
    localparam int CH_W        = 2;
    localparam int WAIT_CYCLES = 2;
    localparam int P           = WAIT_CYCLES + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cs_n = 1'b1;
    logic              prio_rot_wr = 1'b0;
    logic              prio_rot_in = 1'b0;
    logic [NUM_CH-1:0] ch_en = '1;
    logic [NUM_CH-1:0] dreq = '0;
    logic              hlda = 1'b0;
    logic              tc = 1'b0;
    logic              hrq, program_mode, state_read, state_write, state_done;
    logic              ior, iow, eop;
    logic [NUM_CH-1:0] dack;
    logic [CH_W-1:0]   ch_sel;

    always #5 clk = ~clk;

    dma_tc_multich #(
        .NUM_CH      (NUM_CH),
        .CH_W        (CH_W),
        .WAIT_CYCLES (WAIT_CYCLES),
        .ROT_PRIO    (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cs_n         (cs_n),
        .prio_rot_wr  (prio_rot_wr),
        .prio_rot_in  (prio_rot_in),
        .ch_en        (ch_en),
        .dreq         (dreq),
        .hlda         (hlda),
        .tc           (tc),
        .hrq          (hrq),
        .program_mode (program_mode),
        .state_read   (state_read),
        .state_write  (state_write),
        .state_done   (state_done),
        .ior          (ior),
        .iow          (iow),
        .dack         (dack),
        .ch_sel       (ch_sel),
        .eop          (eop)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // One record per granted block: channel, strobe cycle counts, eop seen.
    typedef struct {
        int ch;
        int n_r;
        int n_w;
        bit eop;
    } exp_t;

    exp_t exp_q[$];
    int   m_ptr  = 0;
    bit   m_mode = 1'b1;

    function automatic int arb(input logic [3:0] rv, input int ptr, input bit rot);
        int base;
        base = rot ? ptr : 0;
        for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = (base + k) % NUM_CH;
            if (rv[c]) return c;
        end
        return -1;
    endfunction

    // Monitor: per-cycle output invariants plus block reconstruction.
    bit  active = 1'b0;
    int  cap_ch, n_r, n_w;
    always @(negedge clk) begin
        bit   inv;
        exp_t e;
        inv = !(ior && iow) && (ior == state_read) && (iow == state_write) &&
              (eop == state_done) && !(eop && hrq) && !(program_mode && hrq) &&
              ((ior || iow) ? (dack == (4'(1) << ch_sel) && hrq) : (dack == '0)) &&
              !(eop && !active);
        check(inv, "invariants", $sformatf("hrq=%b pm=%b rd=%b wr=%b dn=%b ior=%b iow=%b dack=%b ch=%0d eop=%b act=%b",
              hrq, program_mode, state_read, state_write, state_done, ior, iow, dack, ch_sel, eop, active));
        if (state_read || state_write) begin
            if (!active) begin
                active = 1'b1;
                cap_ch = int'(ch_sel);
                n_r    = 0;
                n_w    = 0;
            end
            check(int'(ch_sel) == cap_ch, "ch_sel_stable", $sformatf("got %0d expected %0d", ch_sel, cap_ch));
            n_r += int'(state_read);
            n_w += int'(state_write);
        end else if (active) begin
            active = 1'b0;
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_block", $sformatf("ch=%0d reads=%0d writes=%0d eop=%b", cap_ch, n_r, n_w, eop));
            end else begin
                e = exp_q.pop_front();
                check(cap_ch == e.ch && n_r == e.n_r && n_w == e.n_w && eop == e.eop, "block",
                      $sformatf("got ch=%0d rd=%0d wr=%0d eop=%b expected ch=%0d rd=%0d wr=%0d eop=%b",
                                cap_ch, n_r, n_w, eop, e.ch, e.n_r, e.n_w, e.eop));
            end
        end
    end

    task automatic go_idle();
        dreq = '0; hlda = 1'b0; tc = 1'b0; cs_n = 1'b1; prio_rot_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; dreq = '1; ch_en = '1; hlda = 1'b0; cs_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({hrq, program_mode, state_read, state_write, state_done, ior, iow, dack, ch_sel, eop} == '0,
                  "reset_outputs", $sformatf("hrq=%b pm=%b ior=%b iow=%b dack=%b ch=%0d eop=%b",
                                             hrq, program_mode, ior, iow, dack, ch_sel, eop));
            @(posedge clk); #1;
        end
        rst_n = 1'b1; dreq = '0;
        m_ptr = 0; m_mode = 1'b1;
    endtask

    task automatic set_mode(input bit v);
        go_idle();
        prio_rot_wr = 1'b1; prio_rot_in = v;
        @(posedge clk); #1;
        prio_rot_wr = 1'b0;
        m_mode = v;
    endtask

    // kind: 0 full block to tc, 1 hlda dropped during READ of word cut, 2 reset during WRITE of word cut.
    task automatic run_block(input logic [3:0] dq, input logic [3:0] en, input int nwords,
                             input int kind, input int cut, input bit scramble);
        int   ch, total, drop_j, rst_j;
        bit   found;
        exp_t e;
        dreq = dq; ch_en = en; hlda = 1'b0; tc = 1'b0; cs_n = 1'b1;
        drop_j = -1; rst_j = -1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = hrq;
        end
        check(found, "hrq_wait", $sformatf("hrq never rose for dreq=%b ch_en=%b", dq, en));
        if (!found) return;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        hlda = 1'b1;
        ch = arb(dq & en, m_ptr, m_mode);
        if (kind == 0) begin
            total = nwords * 2 * P;
            e = '{ch, nwords * P, nwords * P, 1'b1};
            if (m_mode) m_ptr = (ch + 1) % NUM_CH;
        end else if (kind == 1) begin
            total  = (cut + 1) * 2 * P;
            drop_j = cut * 2 * P + $urandom_range(0, P - 1);
            e = '{ch, (cut + 1) * P, (cut + 1) * P, 1'b0};
        end else begin
            rst_j = cut * 2 * P + P + $urandom_range(0, P - 1);
            total = rst_j + 1;
            e = '{ch, (cut + 1) * P, cut * P + (rst_j - cut * 2 * P - P + 1), 1'b0};
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        for (int j = 0; j < total; j++) begin
            if ((j % (2 * P)) == 2 * P - 1) tc = (kind == 0) && (j / (2 * P) == nwords - 1);
            else                            tc = 1'($urandom_range(0, 1));
            if (scramble) begin
                dreq = 4'($urandom); ch_en = 4'($urandom);
                cs_n = 1'($urandom_range(0, 1));
                prio_rot_wr = (j == 0); prio_rot_in = ~m_mode;
            end
            if (j == drop_j) hlda = 1'b0;
            if (j == rst_j)  rst_n = 1'b0;
            if (j == 0) begin
                @(negedge clk);
                check(ior == 1'b1, "hlda_to_ior", $sformatf("ior=%b expected 1 one clk after hlda", ior));
            end
            @(posedge clk); #1;
            prio_rot_wr = 1'b0;
        end
        hlda = 1'b0; tc = 1'b0; cs_n = 1'b1;
        if (kind == 2) begin
            rst_n = 1'b1; dreq = '0;
            m_ptr = 0; m_mode = 1'b1;
            @(negedge clk);
            check(!iow && !ior && dack == '0 && !hrq && !eop, "reset_mid_write",
                  $sformatf("iow=%b ior=%b dack=%b hrq=%b eop=%b expected all 0", iow, ior, dack, hrq, eop));
        end
    endtask

    initial begin
        logic [3:0] dq, en;
        int         nw, kind;

        do_reset();

        // Request latency then a single word on channel 2.
        @(posedge clk); #1;
        dreq = 4'b0100;
        @(negedge clk);
        check(hrq == 1'b0, "hrq_before", $sformatf("hrq=%b expected 0", hrq));
        @(posedge clk); @(negedge clk);
        check(hrq == 1'b1, "hrq_latency", $sformatf("hrq=%b expected 1", hrq));
        run_block(4'b0100, 4'hF, 1, 0, 0, 1'b0);
        go_idle();
        run_block(4'b1000, 4'hF, 3, 0, 0, 1'b0);

        // Rotating then fixed priority with a held request pattern.
        do_reset();
        for (int i = 0; i < 4; i++) run_block(4'b1011, 4'hF, $urandom_range(1, 2), 0, 0, 1'b0);
        set_mode(1'b0);
        for (int i = 0; i < 4; i++) run_block(4'b1011, 4'hF, $urandom_range(1, 2), 0, 0, 1'b0);

        // CPU wins over a pending request in IDLE.
        go_idle();
        cs_n = 1'b0; dreq = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check(program_mode && !hrq, "cpu_priority", $sformatf("program_mode=%b hrq=%b expected 1/0", program_mode, hrq));
        end
        @(posedge clk); #1;
        cs_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check(!program_mode && hrq, "cpu_release", $sformatf("program_mode=%b hrq=%b expected 0/1", program_mode, hrq));
        run_block(4'b0010, 4'hF, 2, 0, 0, 1'b0);

        // Bus grant lost mid-READ, then reset mid-WRITE and a clean restart.
        run_block(4'b0110, 4'hF, 3, 1, 1, 1'b0);
        run_block(4'b1100, 4'hF, 3, 2, 1, 1'b0);
        run_block(4'b1100, 4'hF, 1, 0, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 7) == 0) set_mode(1'($urandom_range(0, 1)));
            do begin
                dq = 4'($urandom);
                en = 4'($urandom);
            end while ((dq & en) == 4'b0);
            nw   = $urandom_range(1, 4);
            kind = ($urandom_range(0, 5) == 0) ? 1 : 0;
            run_block(dq, en, nw, kind, $urandom_range(0, nw - 1), 1'b1);
        end

        go_idle();
        repeat (5) @(posedge clk);
        check(exp_q.size() == 0, "scoreboard_drain", $sformatf("%0d expected blocks never observed", exp_q.size()));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, %0d checks %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
